sha3_padder: RTL and testbench

SHA3_PADDER -- requirements
Module: sha3_padder

---
 rtl/sha3_pkg.sv | 49 ++++
 rtl/sha3_pad_word.sv | 30 +++
 rtl/sha3_padder.sv | 189 ++++++++++++++++++
 tb/tb_sha3_padder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared constants for the SHA-3 padder: rate encodings, domain bytes and FSM states.
package sha3_pkg;

    typedef enum logic [1:0] {
        MODE_576  = 2'b00,
        MODE_832  = 2'b01,
        MODE_1152 = 2'b10,
        MODE_1088 = 2'b11
    } sha3_mode_e;

    typedef enum logic [1:0] {
        ST_ABSORB = 2'b00,
        ST_EMIT   = 2'b01,
        ST_PADBLK = 2'b10
    } pad_state_e;

    localparam logic [4:0] WORDS_576  = 5'd9;
    localparam logic [4:0] WORDS_832  = 5'd13;
    localparam logic [4:0] WORDS_1088 = 5'd17;
    localparam logic [4:0] WORDS_1152 = 5'd18;

    localparam logic [7:0] BYTES_576  = 8'd72;
    localparam logic [7:0] BYTES_832  = 8'd104;
    localparam logic [7:0] BYTES_1088 = 8'd136;
    localparam logic [7:0] BYTES_1152 = 8'd144;

    localparam logic [7:0] DOM_SHA3  = 8'h06;
    localparam logic [7:0] DOM_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END   = 8'h80;

    function automatic logic [4:0] rate_words(input logic [1:0] m);
        case (m)
            MODE_576:  return WORDS_576;
            MODE_832:  return WORDS_832;
            MODE_1088: return WORDS_1088;
            default:   return WORDS_1152;
        endcase
    endfunction

    function automatic logic [7:0] rate_bytes(input logic [1:0] m);
        case (m)
            MODE_576:  return BYTES_576;
            MODE_832:  return BYTES_832;
            MODE_1088: return BYTES_1088;
            default:   return BYTES_1152;
        endcase
    endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Combinational word masker: on the final word, clears bytes past nbytes_i and drops the domain byte after the data.
module sha3_pad_word
    import sha3_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [3:0]  nbytes_i,
    input  logic        final_i,
    input  logic [7:0]  domain_i,
    output logic [63:0] word_o
);

    // Byte 0 sits in the top lane; nbytes_i == 8 passes the word through untouched.
    always_comb begin
        word_o = word_i;
        if (final_i) begin
            for (int b = 0; b < 8; b++) begin
                if (4'(b) > nbytes_i) begin
                    word_o[63-8*b -: 8] = 8'h00;
                end else if (4'(b) == nbytes_i) begin
                    word_o[63-8*b -: 8] = domain_i;
                end else begin
                    word_o[63-8*b -: 8] = word_i[63-8*b -: 8];
                end
            end
        end else begin
            word_o = word_i;
        end
    end

endmodule

// File: rtl/sha3_padder.sv
// SHA-3 multi-rate padder: packs 64-bit words into rate-sized blocks and applies pad10*1 with a domain byte.
// Optional macro SHA3_PADDER_SHAKE_EN adds the xof input selecting the SHAKE domain byte.
module sha3_padder
    import sha3_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
`ifdef SHA3_PADDER_SHAKE_EN
    input  logic          xof,
`endif
    input  logic [63:0]   in_data,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic [3:0]    in_bytes,
    output logic          in_ready,
    output logic [1151:0] blk_data,
    output logic [1:0]    blk_mode,
    output logic          blk_valid,
    input  logic          blk_ready,
    output logic          blk_last
);

    pad_state_e    state_q, state_d;
    logic [4:0]    w_q, w_d;
    logic [1:0]    mode_q, mode_d;
    logic          xof_q, xof_d, last_q, last_d, pend_q, pend_d, msg_q, msg_d;
    logic [1151:0] buf_q, buf_d;

    logic          xof_in_s, accept_s, xof_eff_s, full_s, pad_full_s;
    logic [1:0]    mode_eff_s;
    logic [4:0]    rw_s;
    logic [7:0]    rb_s, rb_q_s, dom_s, dom_q_s;
    logic [3:0]    nbytes_s;
    logic [10:0]   wbase_s, endpos_s, endpos_q_s;
    logic [63:0]   word_s;

`ifdef SHA3_PADDER_SHAKE_EN
    assign xof_in_s = xof;
`else
    assign xof_in_s = 1'b0;
`endif

    // Mode and xof are frozen for the rest of a message once its first word is taken.
    assign accept_s   = in_valid && (state_q == ST_ABSORB);
    assign mode_eff_s = msg_q ? mode_q : mode;
    assign xof_eff_s  = msg_q ? xof_q : xof_in_s;
    assign rw_s       = rate_words(mode_eff_s);
    assign rb_s       = rate_bytes(mode_eff_s);
    assign rb_q_s     = rate_bytes(mode_q);
    assign nbytes_s   = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign dom_s      = xof_eff_s ? DOM_SHAKE : DOM_SHA3;
    assign dom_q_s    = xof_q ? DOM_SHAKE : DOM_SHA3;
    assign full_s     = (w_q == (rw_s - 5'd1));
    assign pad_full_s = in_last && full_s && (nbytes_s == 4'd8);
    assign wbase_s    = 11'd1151 - {w_q, 6'd0};
    assign endpos_s   = 11'd1151 - {rb_s - 8'd1, 3'd0};
    assign endpos_q_s = 11'd1151 - {rb_q_s - 8'd1, 3'd0};

    sha3_pad_word u_pad_word (
        .word_i   (in_data),
        .nbytes_i (nbytes_s),
        .final_i  (in_last),
        .domain_i (dom_s),
        .word_o   (word_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ABSORB;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ABSORB: begin
                if (accept_s && (full_s || in_last)) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_ABSORB;
                end
            end
            ST_EMIT: begin
                if (blk_ready) begin
                    state_d = pend_q ? ST_PADBLK : ST_ABSORB;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_PADBLK: state_d = ST_EMIT;
            default:   state_d = ST_ABSORB;
        endcase
    end

    // Output decode.
    always_comb begin
        in_ready  = (state_q == ST_ABSORB);
        blk_valid = (state_q == ST_EMIT);
    end

    assign blk_data = buf_q;
    assign blk_mode = mode_q;
    assign blk_last = last_q;

    // Block buffer and message bookkeeping next-state.
    always_comb begin
        buf_d  = buf_q;
        w_d    = w_q;
        mode_d = mode_q;
        xof_d  = xof_q;
        last_d = last_q;
        pend_d = pend_q;
        msg_d  = msg_q;
        case (state_q)
            ST_ABSORB: begin
                if (accept_s) begin
                    mode_d = mode_eff_s;
                    xof_d  = xof_eff_s;
                    msg_d  = !in_last;
                    w_d    = w_q + 5'd1;
                    buf_d[wbase_s -: 64] = word_s;
                    if (in_last && !pad_full_s) begin
                        // A full final word pushes the domain byte to the start of the next word.
                        if (nbytes_s == 4'd8) begin
                            buf_d[wbase_s - 11'd64 -: 8] = dom_s;
                        end else begin
                            buf_d[wbase_s -: 64] = word_s;
                        end
                        buf_d[endpos_s -: 8] = buf_d[endpos_s -: 8] | PAD_END;
                        last_d = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        last_d = 1'b0;
                        pend_d = pad_full_s;
                    end
                end else begin
                    w_d = w_q;
                end
            end
            ST_EMIT: begin
                if (blk_ready) begin
                    buf_d  = '0;
                    w_d    = 5'd0;
                    pend_d = 1'b0;
                end else begin
                    buf_d = buf_q;
                end
            end
            ST_PADBLK: begin
                buf_d                  = '0;
                buf_d[1151 -: 8]       = dom_q_s;
                buf_d[endpos_q_s -: 8] = PAD_END;
                last_d                 = 1'b1;
                w_d                    = 5'd0;
            end
            default: begin
                buf_d = '0;
                w_d   = 5'd0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            w_q    <= 5'd0;
            mode_q <= 2'b00;
            xof_q  <= 1'b0;
            last_q <= 1'b0;
            pend_q <= 1'b0;
            msg_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            w_q    <= w_d;
            mode_q <= mode_d;
            xof_q  <= xof_d;
            last_q <= last_d;
            pend_q <= pend_d;
            msg_q  <= msg_d;
        end
    end

endmodule

// File: tb/tb_sha3_padder.sv
// Self-checking bench for sha3_padder: random messages against a byte-level pad10*1 reference model.
module tb_sha3_padder;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [63:0]   in_data = 64'd0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [3:0]    in_bytes = 4'd0;
    logic          in_ready;
    logic [1151:0] blk_data;
    logic [1:0]    blk_mode;
    logic          blk_valid;
    logic          blk_ready = 1'b0;
    logic          blk_last;

    int checks = 0;
    int errors = 0;

    byte unsigned  msg[$];
    logic [1151:0] exp_q[$];

    always #5 clk = ~clk;

    sha3_padder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_mode  (blk_mode),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_last  (blk_last)
    );

    function automatic int rate_of(input logic [1:0] m);
        case (m)
            2'b00:   return 72;
            2'b01:   return 104;
            2'b11:   return 136;
            default: return 144;
        endcase
    endfunction

    // Reference: message || 0x06, zero-fill to a multiple of the rate, OR 0x80 into the final byte.
    task automatic build_expect(input logic [1:0] md);
        byte unsigned  p[$];
        logic [1151:0] v;
        int            rb;
        rb = rate_of(md);
        p = msg;
        p.push_back(8'h06);
        while ((p.size() % rb) != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        exp_q.delete();
        for (int b = 0; b < p.size() / rb; b++) begin
            v = '0;
            for (int k = 0; k < rb; k++) v[1151-8*k -: 8] = p[b*rb+k];
            exp_q.push_back(v);
        end
    endtask

    function automatic logic [63:0] make_word(input int idx);
        logic [63:0] w;
        int          pos;
        for (int j = 0; j < 8; j++) begin
            pos = 8*idx + j;
            w[63-8*j -: 8] = (pos < msg.size()) ? msg[pos] : 8'($urandom);
        end
        return w;
    endfunction

    // Drives msg as words (scrambling mode after word 0) while collecting and checking every block.
    task automatic send_and_check(input logic [1:0] md, input bit tail_empty, input int ready_pct);
        int L, nw, nexp;
        L = msg.size();
        nw = (L == 0) ? 1 : (L + 7) / 8;
        if (tail_empty && L > 0 && (L % 8) == 0) nw++;
        nexp = exp_q.size();
        @(posedge clk); #1;
        fork
            begin
                int idx, guard, nb;
                bit acc;
                idx = 0;
                guard = 0;
                while (idx < nw && guard < 3000) begin
                    nb = L - 8*idx;
                    if (nb > 8) nb = 8;
                    if (nb < 0) nb = 0;
                    mode     = (idx == 0) ? md : 2'($urandom);
                    in_data  = make_word(idx);
                    in_valid = 1'b1;
                    in_last  = (idx == nw - 1);
                    in_bytes = (idx == nw - 1) ? 4'(nb) : 4'($urandom);
                    @(negedge clk);
                    acc = in_ready;
                    @(posedge clk); #1;
                    if (acc) idx++;
                    guard++;
                end
                in_valid = 1'b0;
                in_last  = 1'b0;
                checks++;
                if (idx != nw) begin
                    errors++;
                    $display("FAIL drv_words sent=%0d required=%0d", idx, nw);
                end
            end
            begin
                int  guard, bad;
                bit  got;
                for (int b = 0; b < nexp; b++) begin
                    got = 1'b0;
                    guard = 0;
                    while (!got && guard < 3000) begin
                        blk_ready = ($urandom_range(99) < ready_pct);
                        @(negedge clk);
                        if (blk_valid && blk_ready) begin
                            got = 1'b1;
                            checks++;
                            if (blk_data !== exp_q[b]) begin
                                bad = 0;
                                for (int k = 143; k >= 0; k--)
                                    if (blk_data[1151-8*k -: 8] !== exp_q[b][1151-8*k -: 8]) bad = k;
                                errors++;
                                $display("FAIL blk_data mode=%0d blk=%0d byte=%0d got=%h exp=%h", md, b, bad,
                                         blk_data[1151-8*bad -: 8], exp_q[b][1151-8*bad -: 8]);
                            end
                            checks++;
                            if (blk_last !== (b == nexp - 1)) begin
                                errors++;
                                $display("FAIL blk_last blk=%0d got=%b exp=%b", b, blk_last, (b == nexp - 1));
                            end
                            checks++;
                            if (blk_mode !== md) begin
                                errors++;
                                $display("FAIL blk_mode blk=%0d got=%0d exp=%0d", b, blk_mode, md);
                            end
                        end
                        @(posedge clk); #1;
                        guard++;
                    end
                    if (!got) begin
                        checks++;
                        errors++;
                        $display("FAIL blk_timeout blk=%0d got=none exp=block", b);
                        break;
                    end
                end
                blk_ready = 1'b0;
            end
        join
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid got=%b exp=0", blk_valid); end
        checks++;
        if (blk_last !== 1'b0) begin errors++; $display("FAIL reset_blk_last got=%b exp=0", blk_last); end
        checks++;
        if (blk_data !== '0) begin errors++; $display("FAIL reset_blk_data got=nonzero exp=zero"); end
        checks++;
        if (blk_mode !== 2'b00) begin errors++; $display("FAIL reset_blk_mode got=%0d exp=0", blk_mode); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_empty_1088();
        msg.delete();
        build_expect(2'b11);
        send_and_check(2'b11, 1'b0, 100);
    endtask

    task automatic test_full_block_576();
        msg.delete();
        for (int i = 0; i < 72; i++) msg.push_back(8'($urandom));
        build_expect(2'b00);
        send_and_check(2'b00, 1'b0, 100);
    endtask

    task automatic test_coincident_1152();
        msg.delete();
        for (int i = 0; i < 143; i++) msg.push_back(8'($urandom));
        build_expect(2'b10);
        send_and_check(2'b10, 1'b0, 70);
    endtask

    task automatic test_partial_832();
        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(8'($urandom));
        msg.push_back(8'hAA);
        msg.push_back(8'hBB);
        msg.push_back(8'hCC);
        build_expect(2'b01);
        send_and_check(2'b01, 1'b0, 100);
    endtask

    // Holds blk_ready low with a competing word on the input; also covers one-cycle latency and no-bubble restart.
    task automatic test_backpressure();
        msg.delete();
        for (int i = 0; i < 3; i++) msg.push_back(8'($urandom));
        build_expect(2'b00);
        @(posedge clk); #1;
        mode = 2'b00; in_data = make_word(0); in_valid = 1'b1; in_last = 1'b1; in_bytes = 4'd3; blk_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_data = {$urandom, $urandom}; in_last = 1'b0; mode = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (blk_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, blk_valid); end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
            checks++;
            if (blk_data !== exp_q[0] || blk_last !== 1'b1) begin
                errors++;
                $display("FAIL bp_stable cyc=%0d got_last=%b exp_last=1 data_ok=%b", c, blk_last, blk_data === exp_q[0]);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got_ready=%b got_valid=%b exp=1/0", in_ready, blk_valid);
        end
        msg.delete();
        for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
        build_expect(2'b11);
        send_and_check(2'b11, 1'b0, 100);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        mode = 2'b00; in_valid = 1'b1; in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (blk_valid !== 1'b0 || blk_data !== '0) begin
                errors++;
                $display("FAIL rstmid_absorb cyc=%0d got_valid=%b exp=0", c, blk_valid);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        mode = 2'b11; in_data = {$urandom, $urandom}; in_valid = 1'b1; in_last = 1'b1; in_bytes = 4'd5;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (blk_valid !== 1'b0 || blk_data !== '0 || blk_last !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_emit got_valid=%b got_last=%b exp=0/0", blk_valid, blk_last);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        msg.delete();
        for (int i = 0; i < 30; i++) msg.push_back(8'($urandom));
        build_expect(2'b01);
        send_and_check(2'b01, 1'b0, 100);
    endtask

    task automatic test_boundaries();
        int rb;
        logic [1:0] md;
        for (int m = 0; m < 4; m++) begin
            md = 2'(m);
            rb = rate_of(md);
            for (int v = 0; v < 4; v++) begin
                msg.delete();
                for (int i = 0; i < ((v == 3) ? 2*rb : rb - 1 + v); i++) msg.push_back(8'($urandom));
                build_expect(md);
                send_and_check(md, 1'($urandom), 100);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] md;
        for (int n = 0; n < 15; n++) begin
            md = 2'($urandom);
            msg.delete();
            for (int i = 0; i < $urandom_range(0, 320); i++) msg.push_back(8'($urandom));
            build_expect(md);
            send_and_check(md, 1'($urandom), $urandom_range(30, 100));
        end
    endtask

    initial begin
        test_reset();
        test_empty_1088();
        test_full_block_576();
        test_coincident_1152();
        test_partial_832();
        test_backpressure();
        test_reset_mid();
        test_boundaries();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
